fa_chunk_share_sched: RTL and testbench

//  - Time-shares one CHUNK-bit ripple adder between NREQ requesters.
//  - The adder is built from the sky130 OSU addf/addh cells via the $fa techmap.
//  - Each request is an OPW = CHUNK*NCHUNK bit add.
//  - The add is sequenced LSB-chunk first over NCHUNK cycles.
//  - Carry is registered between chunks, so only one CHUNK-wide carry chain exists in silicon.
//  - Sits between the arithmetic clients and the shared adder: arbiter + sequencer + result buffer.

---
 rtl/fa_chunk_share_sched.sv | 186 ++++++++++++++++++
 tb/tb_fa_chunk_share_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_chunk_share_sched.sv
// rtl/fa_chunk_share_sched.sv - round-robin scheduler time-sharing one CHUNK-bit adder
//
// Purpose: NREQ requesters share a single CHUNK-wide ripple adder. An accepted
// OPW = CHUNK*NCHUNK bit add is sequenced LSB chunk first over NCHUNK cycles,
// with the carry registered between chunks. The result is held until consumed.
//
// Optional feature macro: FA_SCHED_SUB_EN (adds req_sub; sub=1 computes A-B).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   req_valid  per-requester operand valid
//   req_ready  one-hot grant, only in IDLE
//   req_a      operand A, requester i at [i*OPW +: OPW]
//   req_b      operand B, same packing
//   req_cin    per-requester carry-in
//   req_sub    per-requester subtract select (FA_SCHED_SUB_EN only)
//   res_valid  result valid (DONE state)
//   res_ready  result consumer ready
//   res_sum    OPW-bit sum
//   res_cout   carry out of the MSB chunk
//   res_id     index of the requester owning the result
//   busy       high in RUN or DONE
module fa_chunk_share_sched #(
    parameter int NREQ   = 4,
    parameter int CHUNK  = 8,
    parameter int NCHUNK = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int OPW = CHUNK * NCHUNK
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_a,
    input  logic [NREQ*OPW-1:0]  req_b,
    input  logic [NREQ-1:0]      req_cin,
`ifdef FA_SCHED_SUB_EN
    input  logic [NREQ-1:0]      req_sub,
`endif
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OPW-1:0]       res_sum,
    output logic                 res_cout,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);

    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [OPW-1:0] sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;

    // Round-robin pick: scan offsets from high to low so the smallest offset
    // from ptr (the first valid at or after ptr, wrapping) is written last.
    logic           win_vld;
    logic [IDW-1:0] win;
    int             arb_idx;

    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        arb_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (req_valid[arb_idx]) begin
                win_vld = 1'b1;
                win     = IDW'(arb_idx);
            end
        end
    end

    // The one shared carry chain. The chunk carry-in is always carry_q: it is
    // loaded with the request's carry-in at accept, then with each chunk's carry.
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_chunk;

    assign a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
    assign {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    // Grant is suppressed while reset is asserted so all outputs read 0.
    logic grant;
    assign grant = rst_n && (state_q == S_IDLE) && win_vld;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        req_ready = '0;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    req_ready[win] = 1'b1;
                    a_d     = req_a[win*OPW +: OPW];
                    b_d     = req_b[win*OPW +: OPW];
                    carry_d = req_cin[win];
`ifdef FA_SCHED_SUB_EN
                    // A - B as A + ~B + 1; the inversion is done once at accept.
                    if (req_sub[win]) begin
                        b_d     = ~req_b[win*OPW +: OPW];
                        carry_d = 1'b1;
                    end
`endif
                    id_d    = win;
                    ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[cnt_q*CHUNK +: CHUNK] = s_chunk;
                carry_d = c_chunk;
                if (int'(cnt_q) == NCHUNK - 1) begin
                    cout_d  = c_chunk;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_fa_chunk_share_sched.sv
// tb/tb_fa_chunk_share_sched.sv - scoreboard bench for fa_chunk_share_sched
module tb_fa_chunk_share_sched;

    localparam int NREQ   = 4;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = 4;
    localparam int IDW    = 2;
    localparam int OPW    = 32;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic [NREQ-1:0]     req_cin;
`ifdef FA_SCHED_SUB_EN
    logic [NREQ-1:0]     req_sub;
`endif
    logic                res_valid;
    logic                res_ready;
    logic [OPW-1:0]      res_sum;
    logic                res_cout;
    logic [IDW-1:0]      res_id;
    logic                busy;

    fa_chunk_share_sched #(.NREQ(NREQ), .CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef FA_SCHED_SUB_EN
        .req_sub   (req_sub),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
    } op_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        int          id;
    } exp_t;

    op_t  ops[$];
    exp_t exps[$];
    bit   served[512];
    int   m_idx;
    int   m_pass, m_total;
    int   t_pass, t_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        t_total++;
        if (act === req) t_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] req);
        m_total++;
        if (act === req) m_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
        op_t o;
        o.req = r; o.a = a; o.b = b; o.cin = cin; o.sub = sub;
        ops.push_back(o);
    endtask

    task automatic add_exp(input logic [31:0] sum, input logic cout, input int id);
        exp_t e;
        e.sum = sum; e.cout = cout; e.id = id;
        exps.push_back(e);
    endtask

    // Requester driver: presents the oldest unserved op of each requester and
    // retires it once its ready bit is seen.
    always begin : driver
        int hs;
        bit f;
        logic [NREQ-1:0]     nv;
        logic [NREQ*OPW-1:0] na, nb;
        logic [NREQ-1:0]     nc, ns;
        nv = '0; na = '0; nb = '0; nc = '0; ns = '0;
        for (int i = 0; i < NREQ; i++) begin
            f = 1'b0;
            for (int k = 0; k < ops.size(); k++) begin
                if (!f && !served[k] && ops[k].req == i) begin
                    f = 1'b1;
                    nv[i] = 1'b1;
                    na[i*OPW +: OPW] = ops[k].a;
                    nb[i*OPW +: OPW] = ops[k].b;
                    nc[i] = ops[k].cin;
                    ns[i] = ops[k].sub;
                end
            end
        end
        req_valid = nv;
        req_a     = na;
        req_b     = nb;
        req_cin   = nc;
`ifdef FA_SCHED_SUB_EN
        req_sub   = ns;
`endif
        @(negedge clk);
        hs = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (rst_n === 1'b1 && req_valid[i] && req_ready[i] === 1'b1) hs = i;
        end
        if (hs >= 0) begin
            f = 1'b0;
            for (int k = 0; k < ops.size(); k++) begin
                if (!f && !served[k] && ops[k].req == hs) begin
                    f = 1'b1;
                    served[k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    end

    // Monitor: grant sanity every cycle, result compared on each retire.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && req_ready !== '0) begin
            mchk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            mchk("ready_to_valid", 32'(|(req_ready & req_valid)), 32'd1);
        end
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (m_idx >= exps.size()) begin
                mchk("unexpected_result", 32'(m_idx < exps.size()), 32'd1);
            end else begin
                mchk("res_sum", res_sum, exps[m_idx].sum);
                mchk("res_cout", 32'(res_cout), 32'(exps[m_idx].cout));
                mchk("res_id", 32'(res_id), 32'(exps[m_idx].id));
                m_idx++;
            end
        end
    end

    task automatic wait_grant(input string name);
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready !== '0) break;
        end
        chk(name, 32'(n < 40), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (m_idx == exps.size() && busy === 1'b0) break;
        end
        chk(name, 32'(n < 300), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int good;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_sum", res_sum, 32'd0);
        chk("rst_res_cout", 32'(res_cout), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: full-width carry ripple, latency
        add_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        add_exp(32'h0000_0000, 1'b1, 0);
        wait_grant("t1_grant_timeout");
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
        end
        chk("t1_latency", 32'(k), 32'd5);
        wait_drain("t1_drain");

        // 2: carry-in crossing chunk 0 -> 1
        add_op(2, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
        add_exp(32'h0000_0100, 1'b0, 2);
        wait_drain("t2_drain");

        // 3: all four valid from reset, order 0,1,2,3,0
        @(posedge clk); #1;
        rst_n = 1'b0;
        add_op(0, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0);
        add_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        add_op(1, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0);
        add_op(2, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        add_op(3, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        add_exp(32'h0000_0010, 1'b0, 0);
        add_exp(32'h0200_0000, 1'b0, 1);
        add_exp(32'h0000_0000, 1'b1, 2);
        add_exp(32'h0001_0000, 1'b0, 3);
        add_exp(32'hFFFF_FFFF, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_drain("t3_drain");

        // 4: back-pressure in DONE, waiting req2 must not be granted
        @(posedge clk); #1;
        res_ready = 1'b0;
        add_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        add_op(2, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        add_exp(32'h2345_6789, 1'b0, 1);
        add_exp(32'h0000_0003, 1'b0, 2);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
        end
        chk("t4_done_timeout", 32'(k < 40), 32'd1);
        good = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (res_valid === 1'b1 && busy === 1'b1 && req_ready === 4'b0000 &&
                req_valid[2] === 1'b1 && res_sum === 32'h2345_6789 &&
                res_cout === 1'b0 && res_id === 2'd1) good++;
        end
        chk("t4_hold_cycles", 32'(good), 32'd10);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_valid_drop", 32'(res_valid), 32'd0);
        wait_drain("t4_drain");

        // 5: reset during RUN cnt=2, pointer returns to 0
        add_op(1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        wait_grant("t5_grant_timeout");
        chk("t5_grant1", 32'(req_ready), 32'h2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_res_valid", 32'(res_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        add_op(3, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        add_op(0, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
        add_exp(32'h0000_0300, 1'b0, 0);
        add_exp(32'h0000_0007, 1'b0, 3);
        wait_grant("t5_regrant_timeout");
        chk("t5_ptr_reset", 32'(req_ready), 32'h1);
        wait_drain("t5_drain");

`ifdef FA_SCHED_SUB_EN
        // 6: subtract, carry-in ignored when sub=1
        add_op(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        add_exp(32'hFFFF_FFFE, 1'b0, 1);
        wait_drain("t6a_drain");
        add_op(1, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        add_exp(32'h0000_0002, 1'b1, 1);
        wait_drain("t6b_drain");
`endif

        chk("results_consumed", 32'(m_idx), 32'(exps.size()));
        $display("%0d/%0d checks passed", t_pass + m_pass, t_total + m_total);
        $finish;
    end

endmodule
